// File: rtl/fetch_decode_seq.sv
// fetch_decode_seq: fetch/decode sequencer for the lab CPU datapath.
//
// Owns the program counter, accepts instruction words over a valid/ready
// handshake, splits each word into opcode/rm/rn and sequences HALT/resume and
// JUMP (with a one-cycle FLUSH bubble after a taken jump).
//
// Optional feature macro: FDSEQ_JZ_EN
//   defined   -> opcode 4 is JZ (taken when zero_flag = 1 at accept)
//   undefined -> opcode 4 is ordinary, zero_flag is ignored
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   resume      in   level; a rising edge releases HALT
//   zero_flag   in   execute-stage zero flag (JZ only)
//   instr_valid in   instr holds the word fetched from pc
//   instr       in   instruction word [IW]
//   instr_ready out  high only in RUN (combinational)
//   pc          out  address of the next instruction to fetch [AW]
//   dec_valid   out  one-cycle pulse, decoded fields valid
//   opcode      out  registered opcode field [OPW]
//   rm          out  registered first register field [REGW]
//   rn          out  registered second register field [REGW]
//   halted      out  high while in HALT
//   jump_en     out  one-cycle pulse when a jump is taken
//   jump_addr   out  registered target of the taken jump [AW]
//
// Parameter constraints: IW == OPW + 2*REGW, AW <= IW - OPW.

module fetch_decode_seq #(
    parameter int unsigned IW   = 16,
    parameter int unsigned OPW  = 4,
    parameter int unsigned REGW = 6,
    parameter int unsigned AW   = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            resume,
    input  logic            zero_flag,
    input  logic            instr_valid,
    input  logic [IW-1:0]   instr,
    output logic            instr_ready,
    output logic [AW-1:0]   pc,
    output logic            dec_valid,
    output logic [OPW-1:0]  opcode,
    output logic [REGW-1:0] rm,
    output logic [REGW-1:0] rn,
    output logic            halted,
    output logic            jump_en,
    output logic [AW-1:0]   jump_addr
);

    typedef enum logic [1:0] {StRun, StFlush, StHalt} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic            resume_q;
    logic            release_q, release_d;
    logic            dec_valid_q;
    logic            jump_en_q;
    logic [OPW-1:0]  opcode_q;
    logic [REGW-1:0] rm_q, rn_q;
    logic [AW-1:0]   jump_addr_q;

    logic            accept;
    logic            is_halt;
    logic            take_jump;
    logic [OPW-1:0]  op_field;
    logic [AW-1:0]   jump_target;

    assign instr_ready = (state_q == StRun);
    assign halted      = (state_q == StHalt);
    assign accept      = instr_valid & instr_ready;

    assign op_field    = instr[IW-1 -: OPW];
    assign jump_target = instr[AW-1:0];
    assign is_halt     = (op_field == OPW'(0));

`ifdef FDSEQ_JZ_EN
    assign take_jump = (op_field == OPW'(3)) | ((op_field == OPW'(4)) & zero_flag);
`else
    assign take_jump = (op_field == OPW'(3));
    logic unused_zero_flag;
    assign unused_zero_flag = zero_flag;
`endif

    // The edge is only registered while halted, so an edge coinciding with the
    // HALT accept (state still RUN) is dropped. The exit happens one edge after
    // detection.
    assign release_d = (state_q == StHalt) & resume & ~resume_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            StRun: begin
                if (accept) begin
                    if (take_jump) begin
                        state_d = StFlush;
                        pc_d    = jump_target;
                    end else begin
                        pc_d = pc_q + AW'(1);
                        if (is_halt) begin
                            state_d = StHalt;
                        end
                    end
                end
            end
            StFlush: state_d = StRun;
            StHalt: begin
                if (release_q) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            pc_q        <= '0;
            resume_q    <= 1'b0;
            release_q   <= 1'b0;
            dec_valid_q <= 1'b0;
            jump_en_q   <= 1'b0;
            opcode_q    <= '0;
            rm_q        <= '0;
            rn_q        <= '0;
            jump_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            resume_q    <= resume;
            release_q   <= release_d;
            dec_valid_q <= accept;
            jump_en_q   <= accept & take_jump;
            if (accept) begin
                opcode_q <= op_field;
                rm_q     <= instr[IW-OPW-1 -: REGW];
                rn_q     <= instr[REGW-1:0];
            end
            if (accept && take_jump) begin
                jump_addr_q <= jump_target;
            end
        end
    end

    assign pc        = pc_q;
    assign dec_valid = dec_valid_q;
    assign jump_en   = jump_en_q;
    assign opcode    = opcode_q;
    assign rm        = rm_q;
    assign rn        = rn_q;
    assign jump_addr = jump_addr_q;

endmodule

// File: tb/tb_fetch_decode_seq.sv
// Self-checking bench for fetch_decode_seq: directed scenarios followed by a
// randomized run against a cycle-level behavioural model.

module tb_fetch_decode_seq;

    localparam int unsigned IW   = 16;
    localparam int unsigned OPW  = 4;
    localparam int unsigned REGW = 6;
    localparam int unsigned AW   = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            resume = 1'b0;
    logic            zero_flag = 1'b0;
    logic            instr_valid = 1'b0;
    logic [IW-1:0]   instr = '0;
    logic            instr_ready;
    logic [AW-1:0]   pc;
    logic            dec_valid;
    logic [OPW-1:0]  opcode;
    logic [REGW-1:0] rm;
    logic [REGW-1:0] rn;
    logic            halted;
    logic            jump_en;
    logic [AW-1:0]   jump_addr;

    int tests = 0;
    int fails = 0;

`ifdef FDSEQ_JZ_EN
    localparam bit JzOn = 1'b1;
`else
    localparam bit JzOn = 1'b0;
`endif

    fetch_decode_seq #(.IW(IW), .OPW(OPW), .REGW(REGW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .resume     (resume),
        .zero_flag  (zero_flag),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .pc         (pc),
        .dec_valid  (dec_valid),
        .opcode     (opcode),
        .rm         (rm),
        .rn         (rn),
        .halted     (halted),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        instr_valid = 1'b0;
        resume      = 1'b0;
        zero_flag   = 1'b0;
        instr       = '0;
        rst         = 1'b1;
        step();
        rst         = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (pc !== 12'h000) begin fails++; $display("FAIL reset_pc got %h want %h", pc, 12'h000); end
        tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", instr_ready); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b want 0", halted); end
        tests++; if (dec_valid !== 1'b0 || jump_en !== 1'b0) begin fails++; $display("FAIL reset_pulses got dv=%b je=%b want 0 0", dec_valid, jump_en); end
        tests++; if ({opcode, rm, rn, jump_addr} !== 28'h0) begin fails++; $display("FAIL reset_fields got %h want 0", {opcode, rm, rn, jump_addr}); end
    endtask

    task automatic test_stream();
        do_reset();
        instr_valid = 1'b1;
        instr = 16'h4F0F;
        step();
        tests++; if (pc !== 12'h001) begin fails++; $display("FAIL stream_pc1 got %h want %h", pc, 12'h001); end
        tests++; if (dec_valid !== 1'b1) begin fails++; $display("FAIL stream_dv1 got %b want 1", dec_valid); end
        tests++; if ({opcode, rm, rn} !== {4'h4, 6'h3C, 6'h0F}) begin fails++; $display("FAIL stream_fields1 got %h/%h/%h want 4/3c/0f", opcode, rm, rn); end
        instr = 16'h4F10;
        step();
        tests++; if (pc !== 12'h002) begin fails++; $display("FAIL stream_pc2 got %h want %h", pc, 12'h002); end
        tests++; if (dec_valid !== 1'b1 || rn !== 6'h10) begin fails++; $display("FAIL stream_dv2 got dv=%b rn=%h want 1 10", dec_valid, rn); end
        instr_valid = 1'b0;
        step();
        tests++; if (dec_valid !== 1'b0 || rn !== 6'h10) begin fails++; $display("FAIL stream_hold got dv=%b rn=%h want 0 10", dec_valid, rn); end
    endtask

    // Continues from test_stream with pc = 2.
    task automatic test_halt_resume();
        instr_valid = 1'b1;
        instr = 16'h0000;
        step();
        tests++; if (halted !== 1'b1 || instr_ready !== 1'b0 || pc !== 12'h003) begin fails++; $display("FAIL halt_enter got h=%b r=%b pc=%h want 1 0 003", halted, instr_ready, pc); end
        tests++; if (dec_valid !== 1'b1) begin fails++; $display("FAIL halt_dv got %b want 1", dec_valid); end
        instr = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++; if (halted !== 1'b1 || pc !== 12'h003 || dec_valid !== 1'b0) begin fails++; $display("FAIL halt_hold%0d got h=%b pc=%h dv=%b want 1 003 0", i, halted, pc, dec_valid); end
        end
        instr_valid = 1'b0;
        resume = 1'b1;
        step();
        tests++; if (halted !== 1'b1) begin fails++; $display("FAIL resume_edge1 got %b want 1", halted); end
        step();
        tests++; if (halted !== 1'b0 || instr_ready !== 1'b1) begin fails++; $display("FAIL resume_edge2 got h=%b r=%b want 0 1", halted, instr_ready); end
        // Re-halt while resume stays high: the level must not release again.
        instr_valid = 1'b1;
        instr = 16'h0000;
        step();
        instr_valid = 1'b0;
        tests++; if (halted !== 1'b1 || pc !== 12'h004) begin fails++; $display("FAIL rehalt got h=%b pc=%h want 1 004", halted, pc); end
        for (int i = 0; i < 5; i++) begin
            step();
            tests++; if (halted !== 1'b1) begin fails++; $display("FAIL level_no_release%0d got %b want 1", i, halted); end
        end
        resume = 1'b0;
        step();
        resume = 1'b1;
        step();
        step();
        tests++; if (halted !== 1'b0 || instr_ready !== 1'b1) begin fails++; $display("FAIL resume_again got h=%b r=%b want 0 1", halted, instr_ready); end
        resume = 1'b0;
    endtask

    task automatic test_jump();
        logic [AW-1:0] exp_pc;
        zero_flag = 1'b0;
        instr_valid = 1'b1;
        instr = 16'h30FF;
        step();
        tests++; if (jump_en !== 1'b1 || jump_addr !== 12'h0FF || pc !== 12'h0FF) begin fails++; $display("FAIL jump_take got je=%b ja=%h pc=%h want 1 0ff 0ff", jump_en, jump_addr, pc); end
        tests++; if (instr_ready !== 1'b0 || dec_valid !== 1'b1) begin fails++; $display("FAIL jump_flush got r=%b dv=%b want 0 1", instr_ready, dec_valid); end
        instr = 16'h1234;
        step();
        tests++; if (instr_ready !== 1'b1 || jump_en !== 1'b0 || dec_valid !== 1'b0 || pc !== 12'h0FF) begin fails++; $display("FAIL jump_bubble got r=%b je=%b dv=%b pc=%h want 1 0 0 0ff", instr_ready, jump_en, dec_valid, pc); end
        step();
        tests++; if (dec_valid !== 1'b1 || pc !== 12'h100 || opcode !== 4'h1) begin fails++; $display("FAIL jump_target_accept got dv=%b pc=%h op=%h want 1 100 1", dec_valid, pc, opcode); end
        // Jump to own address.
        exp_pc = 12'h100;
        instr = 16'h3100;
        step();
        instr_valid = 1'b0;
        tests++; if (jump_en !== 1'b1 || pc !== exp_pc) begin fails++; $display("FAIL jump_self got je=%b pc=%h want 1 %h", jump_en, pc, exp_pc); end
        step();
    endtask

    task automatic test_wrap();
        zero_flag = 1'b0;
        instr_valid = 1'b1;
        instr = 16'h3FFF;
        step();
        instr_valid = 1'b0;
        step();
        tests++; if (pc !== 12'hFFF || instr_ready !== 1'b1) begin fails++; $display("FAIL wrap_setup got pc=%h r=%b want fff 1", pc, instr_ready); end
        instr_valid = 1'b1;
        instr = 16'h4000;
        step();
        instr_valid = 1'b0;
        tests++; if (pc !== 12'h000 || dec_valid !== 1'b1 || jump_en !== 1'b0) begin fails++; $display("FAIL wrap_pc got pc=%h dv=%b je=%b want 000 1 0", pc, dec_valid, jump_en); end
    endtask

    task automatic test_async_reset();
        do_reset();
        instr_valid = 1'b1;
        instr = 16'h0000;
        step();
        instr_valid = 1'b0;
        step();
        tests++; if (halted !== 1'b1 || pc !== 12'h001) begin fails++; $display("FAIL areset_setup got h=%b pc=%h want 1 001", halted, pc); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (halted !== 1'b0 || pc !== 12'h000 || instr_ready !== 1'b1) begin fails++; $display("FAIL areset_async got h=%b pc=%h r=%b want 0 000 1", halted, pc, instr_ready); end
        rst = 1'b0;
        step();
        tests++; if (halted !== 1'b0 || pc !== 12'h000) begin fails++; $display("FAIL areset_after got h=%b pc=%h want 0 000", halted, pc); end
    endtask

    task automatic test_jz();
        logic [AW-1:0] exp_pc;
        do_reset();
        zero_flag = 1'b1;
        instr_valid = 1'b1;
        instr = 16'h4010;
        step();
        instr_valid = 1'b0;
        exp_pc = JzOn ? 12'h010 : 12'h001;
        tests++; if (pc !== exp_pc || jump_en !== JzOn) begin fails++; $display("FAIL jz_zero1 got pc=%h je=%b want %h %b", pc, jump_en, exp_pc, JzOn); end
        step();
        zero_flag = 1'b0;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        exp_pc = exp_pc + 12'h001;
        tests++; if (pc !== exp_pc || jump_en !== 1'b0 || dec_valid !== 1'b1) begin fails++; $display("FAIL jz_zero0 got pc=%h je=%b dv=%b want %h 0 1", pc, jump_en, dec_valid, exp_pc); end
    endtask

    // Randomized run against a behavioural model: flags for halted/bubble plus
    // an "armed" bit that counts one edge between resume detection and exit.
    task automatic test_random();
        logic [AW-1:0]   m_pc;
        logic [OPW-1:0]  m_op;
        logic [REGW-1:0] m_rm, m_rn;
        logic [AW-1:0]   m_ja;
        bit m_halted, m_bubble, m_armed, m_prev_res, m_dv, m_je, m_ready, acc, jmp;
        bit n_halted, n_armed;
        logic [OPW-1:0] op;
        int r;
        do_reset();
        m_pc = '0; m_op = '0; m_rm = '0; m_rn = '0; m_ja = '0;
        m_halted = 0; m_bubble = 0; m_armed = 0; m_prev_res = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            instr_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 15);
            if (r == 0) op = 4'h0;
            else if (r <= 3) op = 4'h3;
            else if (r <= 6) op = 4'h4;
            else op = 4'($urandom_range(1, 15));
            instr = {op, 12'($urandom())};
            if ($urandom_range(0, 3) == 0) resume = ~resume;
            zero_flag = $urandom_range(0, 1) != 0;
            #1;
            m_ready = !m_halted && !m_bubble;
            tests++; if (instr_ready !== m_ready) begin fails++; $display("FAIL rnd_ready cyc%0d got %b want %b", cyc, instr_ready, m_ready); end
            acc = instr_valid && m_ready;
            m_dv = acc;
            m_je = 0;
            n_halted = m_halted;
            n_armed = 0;
            if (m_halted) begin
                if (m_armed) n_halted = 0;
                else n_armed = resume && !m_prev_res;
            end
            m_bubble = 0;
            if (acc) begin
                m_op = op;
                m_rm = instr[11:6];
                m_rn = instr[5:0];
                jmp = (op == 4'h3) || (JzOn && op == 4'h4 && zero_flag);
                if (jmp) begin
                    m_pc = instr[11:0];
                    m_ja = instr[11:0];
                    m_je = 1;
                    m_bubble = 1;
                end else begin
                    m_pc = m_pc + 12'h001;
                    if (op == 4'h0) n_halted = 1;
                end
            end
            m_halted = n_halted;
            m_armed = n_armed;
            m_prev_res = resume;
            step();
            tests++; if (pc !== m_pc) begin fails++; $display("FAIL rnd_pc cyc%0d got %h want %h", cyc, pc, m_pc); end
            tests++; if (dec_valid !== m_dv || jump_en !== m_je) begin fails++; $display("FAIL rnd_pulses cyc%0d got dv=%b je=%b want %b %b", cyc, dec_valid, jump_en, m_dv, m_je); end
            tests++; if (halted !== m_halted) begin fails++; $display("FAIL rnd_halted cyc%0d got %b want %b", cyc, halted, m_halted); end
            tests++; if ({opcode, rm, rn, jump_addr} !== {m_op, m_rm, m_rn, m_ja}) begin fails++; $display("FAIL rnd_fields cyc%0d got %h want %h", cyc, {opcode, rm, rn, jump_addr}, {m_op, m_rm, m_rn, m_ja}); end
        end
        instr_valid = 1'b0;
        resume = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_stream();
        test_halt_resume();
        test_jump();
        test_wrap();
        test_async_reset();
        test_jz();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
